stdp_synapse: RTL and testbench

Single plastic synapse for the STDP demo neuron path. It sits directly upstream of the LIF neuron: it converts presynaptic spikes into a weighted input current for the neuron. It also consumes the neuron's output spike as the postsynaptic event. Pre/post spike timing is tracked with saturating window timers, and the stored 8-bit weight is potentiated (pre before post) or depressed (post before pre) with saturation.

---
 rtl/stdp_pkg.sv | 25 ++
 rtl/stdp_synapse_spike_timer.sv | 27 ++
 rtl/stdp_synapse.sv | 94 +++++++++
 tb/tb_stdp_synapse.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared widths, types and the weight saturation helper for the STDP synapse.
// Latency: n/a (pure declarations and a combinational function).
// Backpressure: n/a.
package stdp_pkg;

  localparam int WEIGHT_W = 8;
  localparam int TIMER_W  = 8;

  typedef logic [WEIGHT_W-1:0] weight_t;
  typedef logic [TIMER_W-1:0]  timer_t;

  // Clamp a 10-bit signed intermediate (range -255..510) to 0..255.
  // Negative -> 0, anything with bit 8 set (256..511) -> 255.
  function automatic weight_t clamp_w(input logic signed [WEIGHT_W+1:0] v);
    weight_t r;
    if (v[WEIGHT_W+1])
      r = '0;
    else if (v[WEIGHT_W])
      r = '1;
    else
      r = v[WEIGHT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/stdp_synapse_spike_timer.sv
// Saturating spike-age timer: 0 on its spike, counts up, holds at WINDOW ("no recent spike").
// Latency: value updates on the rising edge after the spike.
// Backpressure: none; a spike every cycle simply keeps the timer at 0.
module spike_timer
  import stdp_pkg::*;
#(
  parameter int WINDOW = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   spike,
  output timer_t t
);

  localparam timer_t WIN = timer_t'(WINDOW);

  // Age counter: clear on spike, otherwise count toward WINDOW and hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      t <= WIN;
    else if (spike)
      t <= '0;
    else if (t < WIN)
      t <= t + 1'b1;
  end

endmodule

// File: rtl/stdp_synapse.sv
// Plastic synapse: weights presynaptic spikes into neuron current, adapts weight by pre/post timing.
// Latency: current, weight and ltp/ltd events all register 1 cycle after the spike edge.
// Backpressure: none; spikes are single-cycle pulses accepted every cycle.
// Optional feature: define STDP_GRADED_EN for shift-decayed step sizes (default: fixed steps).
module stdp_synapse
  import stdp_pkg::*;
#(
  parameter int WINDOW    = 16,
  parameter int A_PLUS    = 8,
  parameter int A_MINUS   = 6,
  parameter int TAU_SHIFT = 2,
  parameter int W_INIT    = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pre_spike,
  input  logic                post_spike,
  input  logic                learn_en,
  input  logic                load_weight,
  input  logic [WEIGHT_W-1:0] weight_in,
  output logic [WEIGHT_W-1:0] current,
  output logic [WEIGHT_W-1:0] weight,
  output logic                ltp_evt,
  output logic                ltd_evt
);

  localparam timer_t  WIN   = timer_t'(WINDOW);
  localparam weight_t PLUS  = weight_t'(A_PLUS);
  localparam weight_t MINUS = weight_t'(A_MINUS);

  timer_t  pre_t;
  timer_t  post_t;
  logic    ltp_cond;
  logic    ltd_cond;
  weight_t ltp_step;
  weight_t ltd_step;
  weight_t ltp_eff;
  weight_t ltd_eff;
  logic signed [WEIGHT_W+1:0] next_sum;

  spike_timer #(.WINDOW(WINDOW)) u_pre_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (pre_spike),
    .t     (pre_t)
  );

  spike_timer #(.WINDOW(WINDOW)) u_post_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (post_spike),
    .t     (post_t)
  );

  // Pairing uses the timer values before this edge, so same-edge pre/post
  // each see the other's old age rather than cancelling.
  assign ltp_cond = post_spike && (pre_t < WIN);
  assign ltd_cond = pre_spike && (post_t < WIN);

`ifdef STDP_GRADED_EN
  // Step halves every 2**TAU_SHIFT cycles of spike separation.
  assign ltp_step = PLUS  >> (pre_t  >> TAU_SHIFT);
  assign ltd_step = MINUS >> (post_t >> TAU_SHIFT);
`else
  assign ltp_step = PLUS;
  assign ltd_step = MINUS;
`endif

  assign ltp_eff = ltp_cond ? ltp_step : '0;
  assign ltd_eff = ltd_cond ? ltd_step : '0;

  // Net update in 10-bit signed so both directions can apply together before clamping.
  assign next_sum = $signed({2'b00, weight}) + $signed({2'b00, ltp_eff})
                  - $signed({2'b00, ltd_eff});

  // Weight register and registered outputs; load overrides learning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight  <= weight_t'(W_INIT);
      current <= '0;
      ltp_evt <= 1'b0;
      ltd_evt <= 1'b0;
    end else begin
      current <= pre_spike ? weight : '0;
      ltp_evt <= learn_en && !load_weight && ltp_cond;
      ltd_evt <= learn_en && !load_weight && ltd_cond;
      if (load_weight)
        weight <= weight_in;
      else if (learn_en)
        weight <= clamp_w(next_sum);
    end
  end

endmodule

// File: tb/tb_stdp_synapse.sv
// Self-checking bench for stdp_synapse: directed scenarios plus random spike traffic
// compared every cycle against a spike-history reference model.
// Defaults WINDOW=16, A_PLUS=8, A_MINUS=6, TAU_SHIFT=2, W_INIT=128.
module tb_stdp_synapse;

  localparam int W      = 16;
  localparam int AP     = 8;
  localparam int AM     = 6;
  localparam int TS     = 2;
  localparam int WI     = 128;
  localparam int NONE   = -1000000;

  logic       clk;
  logic       rst_n;
  logic       pre_spike;
  logic       post_spike;
  logic       learn_en;
  logic       load_weight;
  logic [7:0] weight_in;
  logic [7:0] current;
  logic [7:0] weight;
  logic       ltp_evt;
  logic       ltd_evt;

  int checks;
  int failures;

  // Reference model: spike history in absolute edge indices.
  int n_edge;
  int last_pre;
  int last_post;
  int m_weight;
  int m_current;
  int m_ltp;
  int m_ltd;

  stdp_synapse dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pre_spike   (pre_spike),
    .post_spike  (post_spike),
    .learn_en    (learn_en),
    .load_weight (load_weight),
    .weight_in   (weight_in),
    .current     (current),
    .weight      (weight),
    .ltp_evt     (ltp_evt),
    .ltd_evt     (ltd_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles elapsed since a spike as seen at edge n_edge, saturating at WINDOW.
  function automatic int age(input int last);
    int a;
    if (last == NONE) return W;
    a = n_edge - last - 1;
    return (a > W) ? W : a;
  endfunction

  function automatic int step_of(input int base, input int a);
`ifdef STDP_GRADED_EN
    return base / (2 ** (a / (2 ** TS)));
`else
    return (a < 0) ? 0 : base;
`endif
  endfunction

  task automatic model_reset();
    n_edge    = 0;
    last_pre  = NONE;
    last_post = NONE;
    m_weight  = WI;
    m_current = 0;
    m_ltp     = 0;
    m_ltd     = 0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, "_weight"},  int'(weight),  m_weight);
    chk({ctx, "_current"}, int'(current), m_current);
    chk({ctx, "_ltp"},     int'(ltp_evt), m_ltp);
    chk({ctx, "_ltd"},     int'(ltd_evt), m_ltd);
    chk({ctx, "_pre_t"},   int'(dut.u_pre_timer.t),  age(last_pre));
    chk({ctx, "_post_t"},  int'(dut.u_post_timer.t), age(last_post));
  endtask

  // Apply the currently driven inputs at the next rising edge, advance the model, compare.
  task automatic tick(input string ctx);
    int pa, qa, nw;
    bit ltp, ltd;
    @(posedge clk);
    #1;
    pa  = age(last_pre);
    qa  = age(last_post);
    ltp = post_spike && (pa < W);
    ltd = pre_spike && (qa < W);
    m_current = pre_spike ? m_weight : 0;
    m_ltp = 0;
    m_ltd = 0;
    if (load_weight) begin
      m_weight = int'(weight_in);
    end else if (learn_en) begin
      nw = m_weight + (ltp ? step_of(AP, pa) : 0) - (ltd ? step_of(AM, qa) : 0);
      m_weight = (nw < 0) ? 0 : (nw > 255) ? 255 : nw;
      m_ltp = ltp;
      m_ltd = ltd;
    end
    if (pre_spike)  last_pre  = n_edge;
    if (post_spike) last_post = n_edge;
    n_edge++;
    check_all(ctx);
  endtask

  task automatic drive(input bit pre, input bit post, input bit learn,
                       input bit load, input int win, input string ctx);
    pre_spike   = pre;
    post_spike  = post;
    learn_en    = learn;
    load_weight = load;
    weight_in   = 8'(win);
    tick(ctx);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(0, 0, 1, 0, 0, "idle");
  endtask

  // Reload a known weight and let both timers saturate.
  task automatic settle(input int w);
    drive(0, 0, 1, 1, w, "load");
    idle(W + 2);
  endtask

  // Asynchronous reset pulse placed between clock edges; checked with no clock edge.
  task automatic async_reset(input string ctx);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    pre_spike   = 0;
    post_spike  = 0;
    learn_en    = 1;
    load_weight = 0;
    weight_in   = 0;
    model_reset();
    #12;
    check_all("por");
    rst_n = 1'b1;

    // Pre at edge 0, post at edge 3 -> LTP of 8.
    settle(128);
    drive(1, 0, 1, 0, 0, "ltp_pre");
    idle(2);
    drive(0, 1, 1, 0, 0, "ltp_post");
    chk("ltp_w136", int'(weight), 136);
    chk("ltp_pulse", int'(ltp_evt), 1);

    // Post at edge 0, pre at edge 5 -> LTD of 3 graded, 6 fixed.
    settle(128);
    drive(0, 1, 1, 0, 0, "ltd_post");
    idle(4);
    drive(1, 0, 1, 0, 0, "ltd_pre");
`ifdef STDP_GRADED_EN
    chk("ltd_w125", int'(weight), 125);
`else
    chk("ltd_w122", int'(weight), 122);
`endif
    chk("ltd_pulse", int'(ltd_evt), 1);

    // Pre at edge 0, post at edge 20 -> outside window.
    settle(128);
    drive(1, 0, 1, 0, 0, "far_pre");
    idle(19);
    drive(0, 1, 1, 0, 0, "far_post");
    chk("far_w128", int'(weight), 128);
    chk("far_noltp", int'(ltp_evt), 0);

    // Current pulse carries the weight for exactly one cycle.
    settle(200);
    drive(1, 0, 0, 0, 0, "cur_pre");
    chk("cur_200", int'(current), 200);
    drive(0, 0, 0, 0, 0, "cur_after");
    chk("cur_zero", int'(current), 0);

    // Upper saturation with LTP still pulsing.
    settle(253);
    for (int r = 0; r < 3; r++) begin
      drive(1, 0, 1, 0, 0, "sat_hi_pre");
      drive(0, 1, 1, 0, 0, "sat_hi_post");
      chk("sat_hi_255", int'(weight), 255);
      chk("sat_hi_evt", int'(ltp_evt), 1);
      idle(W + 2);
    end

    // Lower saturation.
    settle(2);
    for (int r = 0; r < 3; r++) begin
      drive(0, 1, 1, 0, 0, "sat_lo_post");
      drive(1, 0, 1, 0, 0, "sat_lo_pre");
      chk("sat_lo_0", int'(weight), 0);
      chk("sat_lo_evt", int'(ltd_evt), 1);
      idle(W + 2);
    end

    // Learning disabled: no change, no events.
    settle(100);
    drive(1, 0, 0, 0, 0, "nolearn_pre");
    drive(0, 1, 0, 0, 0, "nolearn_post");
    chk("nolearn_w", int'(weight), 100);
    chk("nolearn_evt", int'(ltp_evt), 0);

    // Load wins over a valid LTP pair on the same edge.
    settle(100);
    drive(1, 0, 1, 0, 0, "ldpri_pre");
    drive(0, 1, 1, 1, 42, "ldpri_post");
    chk("ldpri_w42", int'(weight), 42);
    chk("ldpri_noltp", int'(ltp_evt), 0);

    // Same-edge pre and post with both timers in window.
    settle(128);
    drive(1, 1, 1, 0, 0, "same_a");
    drive(1, 1, 1, 0, 0, "same_b");

    // Mid-operation asynchronous reset.
    drive(1, 0, 1, 0, 0, "pre_rst");
    async_reset("arst");

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 90, $urandom_range(0, 99) < 3,
            int'($urandom_range(0, 255)), "rnd");
      if (i == 700) async_reset("arst_rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
